// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-state data-memory responder for the core load/store port
// Accepts one request at a time, commits stores at acceptance, returns a one-cycle response.
module dmem_responder #(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_adr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_we,
  input  logic              req_ld,
  input  logic              req_str,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_adr;
  logic              r_ld;
  logic              r_str;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic [31:0]       r_mem [2**ADDR_W];

  logic              w_accept;
  logic              w_enter_resp;
  logic              w_ld;
  logic              w_str;
  logic [ADDR_W-1:0] w_adr;

  assign req_ready = (r_state != S_WAIT);
  assign rsp_valid = (r_state == S_RESP);
  assign busy      = (r_state != S_IDLE);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  // Nothing is accepted (and nothing written) while reset is asserted.
  assign w_accept = reset && req_valid && req_ready;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_RESP: begin
        if (w_accept) w_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        else          w_next = S_IDLE;
      end
      S_WAIT: begin
        if (r_cnt == 4'd1) w_next = S_RESP;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_enter_resp = (w_next == S_RESP);

  // With no wait states the response is formed on the accept edge itself.
  assign w_adr = w_accept ? req_adr : r_adr;
  assign w_ld  = w_accept ? req_ld  : r_ld;
  assign w_str = w_accept ? req_str : r_str;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept)                r_cnt <= 4'(WAIT_CYCLES);
      else if (r_state == S_WAIT)  r_cnt <= r_cnt - 4'd1;
      if (w_enter_resp) begin
        r_err   <= (w_ld == w_str);
        r_rdata <= (w_ld && !w_str) ? r_mem[w_adr] : 32'd0;
      end else begin
        r_err   <= 1'b0;
        r_rdata <= 32'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_adr <= req_adr;
      r_ld  <= req_ld;
      r_str <= req_str;
    end
  end

  // Storage survives reset; stores land on the acceptance edge.
  always_ff @(posedge clk) begin
    if (w_accept && req_str && !req_ld) begin
      for (int i = 0; i < 4; i++) begin
        if (req_we[i]) r_mem[req_adr][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - bench for dmem_responder at WAIT_CYCLES 2, 0 and 3
// Three instances share one reference model of memory contents and response timing.
module tb_dmem_responder;

  localparam int AW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  logic          rst_n [3];
  logic          vld   [3];
  logic [AW-1:0] adr   [3];
  logic [31:0]   wd    [3];
  logic [3:0]    we    [3];
  logic          ld    [3];
  logic          st    [3];
  logic          rdy   [3];
  logic          rv    [3];
  logic [31:0]   rd    [3];
  logic          er    [3];
  logic          bsy   [3];

  dmem_responder #(.ADDR_W(AW), .WAIT_CYCLES(2)) u0 (
    .clk(clk), .reset(rst_n[0]), .req_valid(vld[0]), .req_ready(rdy[0]),
    .req_adr(adr[0]), .req_wdata(wd[0]), .req_we(we[0]), .req_ld(ld[0]), .req_str(st[0]),
    .rsp_valid(rv[0]), .rsp_rdata(rd[0]), .rsp_err(er[0]), .busy(bsy[0]));
  dmem_responder #(.ADDR_W(AW), .WAIT_CYCLES(0)) u1 (
    .clk(clk), .reset(rst_n[1]), .req_valid(vld[1]), .req_ready(rdy[1]),
    .req_adr(adr[1]), .req_wdata(wd[1]), .req_we(we[1]), .req_ld(ld[1]), .req_str(st[1]),
    .rsp_valid(rv[1]), .rsp_rdata(rd[1]), .rsp_err(er[1]), .busy(bsy[1]));
  dmem_responder #(.ADDR_W(AW), .WAIT_CYCLES(3)) u2 (
    .clk(clk), .reset(rst_n[2]), .req_valid(vld[2]), .req_ready(rdy[2]),
    .req_adr(adr[2]), .req_wdata(wd[2]), .req_we(we[2]), .req_ld(ld[2]), .req_str(st[2]),
    .rsp_valid(rv[2]), .rsp_rdata(rd[2]), .rsp_err(er[2]), .busy(bsy[2]));

  function automatic int wcyc(input int k);
    return (k == 0) ? 2 : (k == 1) ? 0 : 3;
  endfunction

  // Reference model: word contents with per-byte "known" flags, plus the one outstanding response.
  logic [31:0] mm  [3][4096];
  logic [3:0]  kn  [3][4096];
  bit          pend [3];
  int          pdue [3];
  logic [31:0] pdat [3];
  logic [31:0] pmsk [3];
  bit          perr [3];
  bit          armed [3];
  bit          acc_flag [3];
  int          acc_cyc [3];
  int          rsp_cnt [3];
  logic [31:0] last_rd [3];
  logic        last_er [3];
  int          last_cyc [3];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  bit e_valid, e_ready, e_busy;

  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      e_valid = pend[k] && (pdue[k] == cyc);
      e_busy  = pend[k];
      e_ready = !(pend[k] && (pdue[k] > cyc));
      if (armed[k]) begin
        chk($sformatf("u%0d_rsp_valid c%0d", k, cyc), 32'(rv[k]),  32'(e_valid));
        chk($sformatf("u%0d_busy c%0d", k, cyc),      32'(bsy[k]), 32'(e_busy));
        chk($sformatf("u%0d_ready c%0d", k, cyc),     32'(rdy[k]), 32'(e_ready));
        if (e_valid) begin
          chk($sformatf("u%0d_err c%0d", k, cyc), 32'(er[k]), 32'(perr[k]));
          chk($sformatf("u%0d_rdata c%0d", k, cyc), rd[k] & pmsk[k], pdat[k] & pmsk[k]);
          pend[k]     = 1'b0;
          rsp_cnt[k]++;
          last_rd[k]  = rd[k];
          last_er[k]  = er[k];
          last_cyc[k] = cyc;
        end else begin
          chk($sformatf("u%0d_idle_rdata c%0d", k, cyc), rd[k], 32'd0);
          chk($sformatf("u%0d_idle_err c%0d", k, cyc), 32'(er[k]), 32'd0);
        end
      end
      acc_flag[k] = 1'b0;
      if (!rst_n[k]) begin
        pend[k]  = 1'b0;
        armed[k] = 1'b1;
      end else if (armed[k] && vld[k] && e_ready) begin
        acc_flag[k] = 1'b1;
        acc_cyc[k]  = cyc + 1;
        pend[k]     = 1'b1;
        pdue[k]     = cyc + 1 + wcyc(k);
        perr[k]     = (ld[k] == st[k]);
        pdat[k]     = 32'd0;
        pmsk[k]     = 32'hFFFF_FFFF;
        if (!perr[k] && st[k]) begin
          for (int i = 0; i < 4; i++) begin
            if (we[k][i]) begin
              mm[k][adr[k]][8*i +: 8] = wd[k][8*i +: 8];
              kn[k][adr[k]][i] = 1'b1;
            end
          end
        end else if (!perr[k] && ld[k]) begin
          pdat[k] = mm[k][adr[k]];
          for (int i = 0; i < 4; i++) pmsk[k][8*i +: 8] = {8{kn[k][adr[k]][i]}};
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int k, input logic [AW-1:0] a, input logic [31:0] d,
                       input logic [3:0] m, input logic l, input logic s);
    int n;
    n = 0;
    adr[k] = a; wd[k] = d; we[k] = m; ld[k] = l; st[k] = s; vld[k] = 1'b1;
    do begin
      step();
      n++;
    end while (!acc_flag[k] && n < 40);
    chk($sformatf("u%0d_accept", k), 32'(acc_flag[k]), 32'd1);
    vld[k] = 1'b0;
  endtask

  task automatic wait_cnt(input int k, input int target);
    int n;
    n = 0;
    while (rsp_cnt[k] < target && n < 40) begin
      step();
      n++;
    end
    chk($sformatf("u%0d_rsp_count", k), 32'(rsp_cnt[k]), 32'(target));
  endtask

  task automatic do_reset(input int k, input int n);
    rst_n[k] = 1'b0;
    repeat (n) step();
    rst_n[k] = 1'b1;
  endtask

  task automatic rand_ops(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      int t;
      logic [AW-1:0] a;
      t = $urandom_range(0, 9);
      a = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 15)) : AW'(12'hFF0 + $urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) do_reset(k, $urandom_range(1, 2));
      repeat ($urandom_range(0, 2)) step();
      issue(k, a, $urandom, 4'($urandom_range(0, 15)),
            (t < 4) || (t == 8), (t >= 4 && t < 8) || (t == 8));
    end
    repeat (6) step();
  endtask

  int c, a0, a1;

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; vld[k] = 1'b0; adr[k] = '0; wd[k] = '0;
      we[k] = '0; ld[k] = 1'b0; st[k] = 1'b0;
      for (int j = 0; j < 4096; j++) kn[k][j] = 4'd0;
    end
    repeat (2) step();
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d_rst_ready", k), 32'(rdy[k]), 32'd1);
      chk($sformatf("u%0d_rst_busy", k),  32'(bsy[k]), 32'd0);
      chk($sformatf("u%0d_rst_valid", k), 32'(rv[k]),  32'd0);
      chk($sformatf("u%0d_rst_rdata", k), rd[k],       32'd0);
    end

    c = rsp_cnt[0];
    issue(0, 12'h010, 32'hDEADBEEF, 4'b1111, 1'b0, 1'b1);
    wait_cnt(0, c + 1);
    chk("st_rdata", last_rd[0], 32'd0);
    chk("st_err", 32'(last_er[0]), 32'd0);
    chk("st_latency_w2", 32'(last_cyc[0] - acc_cyc[0]), 32'd2);
    issue(0, 12'h010, 32'd0, 4'b0000, 1'b1, 1'b0);
    wait_cnt(0, c + 2);
    chk("ld_full_word", last_rd[0], 32'hDEADBEEF);

    issue(0, 12'h010, 32'h000000AA, 4'b0001, 1'b0, 1'b1);
    issue(0, 12'h010, 32'h55660000, 4'b1100, 1'b0, 1'b1);
    issue(0, 12'h010, 32'd0, 4'b0000, 1'b1, 1'b0);
    wait_cnt(0, c + 5);
    chk("ld_byte_merge", last_rd[0], 32'h5566BEAA);

    issue(0, 12'h030, 32'h0BADCAFE, 4'b1111, 1'b0, 1'b1);
    issue(0, 12'h030, 32'hFFFFFFFF, 4'b1111, 1'b1, 1'b1);
    wait_cnt(0, c + 7);
    chk("both_err", 32'(last_er[0]), 32'd1);
    chk("both_rdata", last_rd[0], 32'd0);
    issue(0, 12'h030, 32'hFFFFFFFF, 4'b1111, 1'b0, 1'b0);
    wait_cnt(0, c + 8);
    chk("none_err", 32'(last_er[0]), 32'd1);
    issue(0, 12'h030, 32'hFFFFFFFF, 4'b0000, 1'b0, 1'b1);
    wait_cnt(0, c + 9);
    chk("we0_err", 32'(last_er[0]), 32'd0);
    chk("we0_rdata", last_rd[0], 32'd0);
    issue(0, 12'h030, 32'd0, 4'b0000, 1'b1, 1'b0);
    wait_cnt(0, c + 10);
    chk("ld_after_err", last_rd[0], 32'h0BADCAFE);

    c = rsp_cnt[1];
    issue(1, 12'h020, 32'h12345678, 4'b1111, 1'b0, 1'b1);
    a0 = acc_cyc[1];
    issue(1, 12'h020, 32'd0, 4'b0000, 1'b1, 1'b0);
    a1 = acc_cyc[1];
    wait_cnt(1, c + 2);
    chk("b2b_accept_gap", 32'(a1 - a0), 32'd1);
    chk("b2b_ld_data", last_rd[1], 32'h12345678);
    chk("b2b_latency_w0", 32'(last_cyc[1] - a1), 32'd0);

    c = rsp_cnt[2];
    issue(2, 12'h040, 32'hCAFEF00D, 4'b1111, 1'b0, 1'b1);
    wait_cnt(2, c + 1);
    chk("st_latency_w3", 32'(last_cyc[2] - acc_cyc[2]), 32'd3);
    issue(2, 12'h040, 32'd0, 4'b0000, 1'b1, 1'b0);
    step();
    do_reset(2, 1);
    repeat (6) step();
    chk("abort_no_rsp", 32'(rsp_cnt[2]), 32'(c + 1));
    chk("abort_ready", 32'(rdy[2]), 32'd1);
    chk("abort_busy", 32'(bsy[2]), 32'd0);
    issue(2, 12'h040, 32'd0, 4'b0000, 1'b1, 1'b0);
    wait_cnt(2, c + 2);
    chk("st_survives_reset", last_rd[2], 32'hCAFEF00D);

    for (int k = 0; k < 3; k++) rand_ops(k, 150);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
